// File: rtl/param_combo_lock_pkg.sv
// Shared types and helpers for the combination-lock core: mode codes, edge detect, width math.
package param_combo_lock_pkg;

    typedef enum logic [1:0] {
        MODE_SET     = 2'b00,
        MODE_LOCKED  = 2'b01,
        MODE_LOCKOUT = 2'b10,
        MODE_OPEN    = 2'b11
    } mode_t;

    // Value the button history registers take out of reset.
    localparam logic BTN_HIST_RST = 1'b0;

    function automatic logic rise(input logic now, input logic prev);
        return now & ~prev;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int width_of(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int cnt_width(input int cycles, input int esc);
        longint span;
        span = longint'(cycles) << esc;
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/param_combo_lock_if.sv
// Switch/button inputs and display/status outputs of the combination-lock core.
interface param_combo_lock_if
    import param_combo_lock_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int DIGIT_W        = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 50000000,
    parameter int MAX_ESC        = 3
);
    localparam int AW    = width_of(MAX_ATTEMPTS);
    localparam int CNT_W = cnt_width(LOCKOUT_CYCLES, MAX_ESC);

    logic [DIGIT_W-1:0]            digit_in;
    logic                          btn_enter;
    logic                          btn_back;
    logic                          btn_change;
    logic                          btn_relock;
    mode_t                         mode;
    logic [NUM_DIGITS*DIGIT_W-1:0] disp_digits;
    logic [NUM_DIGITS-1:0]         disp_mask;
    logic [AW-1:0]                 attempts_left;
    logic [CNT_W-1:0]              lockout_remain;
    logic                          ok_pulse;
    logic                          fail_pulse;
    logic                          err_pulse;

    modport master (
        output digit_in, btn_enter, btn_back, btn_change, btn_relock,
        input  mode, disp_digits, disp_mask, attempts_left, lockout_remain,
               ok_pulse, fail_pulse, err_pulse
    );

    modport slave (
        input  digit_in, btn_enter, btn_back, btn_change, btn_relock,
        output mode, disp_digits, disp_mask, attempts_left, lockout_remain,
               ok_pulse, fail_pulse, err_pulse
    );

endinterface

// File: rtl/param_combo_lock_lockout_timer.sv
// Purpose: lockout down-counter, load value LOCKOUT_CYCLES << level.
// Latency: count visible the cycle after load; done is combinational on count==1.
// Backpressure: none; decrements every cycle until zero.
module param_combo_lock_lockout_timer
    import param_combo_lock_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 50000000,
    parameter int MAX_ESC        = 3
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           load,
    input  logic [width_of(MAX_ESC)-1:0]                   level,
    output logic [cnt_width(LOCKOUT_CYCLES, MAX_ESC)-1:0]  count,
    output logic                                           done
);
    localparam int CNT_W = cnt_width(LOCKOUT_CYCLES, MAX_ESC);
    localparam logic [CNT_W-1:0] BASE = CNT_W'(LOCKOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= BASE << level;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/param_combo_lock.sv
// Purpose: combination-lock core, digit entry with SET/LOCKED/LOCKOUT/OPEN modes and escalating lockout.
// Latency: button action registered the cycle after its rising edge; evaluation one cycle after the last digit.
// Backpressure: none; button edges arriving in ignored modes are dropped.
module param_combo_lock
    import param_combo_lock_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int DIGIT_W        = 4,
    parameter int DIGIT_MAX      = 9,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 50000000,
    parameter int MAX_ESC        = 3,
    parameter int MASK_ENTRY     = 1
) (
    input logic               clk,
    input logic               rst,
    param_combo_lock_if.slave lk
);
    localparam int PW    = width_of(NUM_DIGITS);
    localparam int AW    = width_of(MAX_ATTEMPTS);
    localparam int LW    = width_of(MAX_ESC);
    localparam int CNT_W = cnt_width(LOCKOUT_CYCLES, MAX_ESC);

    mode_t                                mode;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   dbuf;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]   password;
    logic [NUM_DIGITS-1:0]                fill;
    logic [PW-1:0]                        pos;
    logic [AW-1:0]                        attempts;
    logic [LW-1:0]                        level;
    logic                                 enter_q, back_q, change_q, relock_q;
    logic                                 ok_q, fail_q, err_q;
    logic                                 enter_e, back_e, change_e, relock_e;
    logic                                 entry_mode, complete, match, lock_now, tmr_done;
    logic [CNT_W-1:0]                     tmr_count;

    assign enter_e    = rise(lk.btn_enter,  enter_q);
    assign back_e     = rise(lk.btn_back,   back_q);
    assign change_e   = rise(lk.btn_change, change_q);
    assign relock_e   = rise(lk.btn_relock, relock_q);

    assign entry_mode = (mode == MODE_SET) || (mode == MODE_LOCKED);
    assign complete   = entry_mode && (pos == PW'(NUM_DIGITS));
    assign match      = (dbuf == password);
    assign lock_now   = complete && (mode == MODE_LOCKED) && !match && (attempts == AW'(1));

    param_combo_lock_lockout_timer #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .MAX_ESC        (MAX_ESC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (lock_now),
        .level (level),
        .count (tmr_count),
        .done  (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mode     <= MODE_SET;
            dbuf     <= '0;
            password <= '0;
            fill     <= '0;
            pos      <= '0;
            attempts <= AW'(MAX_ATTEMPTS);
            level    <= '0;
            enter_q  <= BTN_HIST_RST;
            back_q   <= BTN_HIST_RST;
            change_q <= BTN_HIST_RST;
            relock_q <= BTN_HIST_RST;
            ok_q     <= 1'b0;
            fail_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            enter_q  <= lk.btn_enter;
            back_q   <= lk.btn_back;
            change_q <= lk.btn_change;
            relock_q <= lk.btn_relock;
            ok_q     <= 1'b0;
            fail_q   <= 1'b0;
            err_q    <= 1'b0;

            case (mode)
                MODE_SET, MODE_LOCKED: begin
                    // A full buffer is evaluated before any new button edge is honoured.
                    if (complete) begin
                        dbuf <= '0;
                        fill <= '0;
                        pos  <= '0;
                        if (mode == MODE_SET) begin
                            password <= dbuf;
                            mode     <= MODE_LOCKED;
                            attempts <= AW'(MAX_ATTEMPTS);
                        end else if (match) begin
                            mode     <= MODE_OPEN;
                            ok_q     <= 1'b1;
                            attempts <= AW'(MAX_ATTEMPTS);
                            level    <= '0;
                        end else begin
                            fail_q   <= 1'b1;
                            attempts <= attempts - 1'b1;
                            if (lock_now) begin
                                mode  <= MODE_LOCKOUT;
                                level <= (level == LW'(MAX_ESC)) ? level : level + 1'b1;
                            end
                        end
                    end else if (enter_e) begin
                        if (int'(lk.digit_in) > DIGIT_MAX) begin
                            err_q <= 1'b1;
                        end else if (pos < PW'(NUM_DIGITS)) begin
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (pos == PW'(i)) begin
                                    dbuf[i] <= lk.digit_in;
                                    fill[i] <= 1'b1;
                                end
                            end
                            pos <= pos + 1'b1;
                        end
                    end else if (back_e && (pos != '0)) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (pos == PW'(i + 1)) begin
                                dbuf[i] <= '0;
                                fill[i] <= 1'b0;
                            end
                        end
                        pos <= pos - 1'b1;
                    end
                end
                MODE_LOCKOUT: begin
                    if (tmr_done) begin
                        mode     <= MODE_LOCKED;
                        attempts <= AW'(MAX_ATTEMPTS);
                    end
                end
                MODE_OPEN: begin
                    if (relock_e) begin
                        mode <= MODE_LOCKED;
                    end else if (change_e) begin
                        mode <= MODE_SET;
                    end
                end
                default: mode <= MODE_SET;
            endcase
        end
    end

    assign lk.mode           = mode;
    assign lk.disp_digits    = ((MASK_ENTRY != 0) && (mode == MODE_LOCKED)) ? '0 : dbuf;
    assign lk.disp_mask      = (mode == MODE_LOCKOUT) ? '0 : fill;
    assign lk.attempts_left  = attempts;
    assign lk.lockout_remain = tmr_count;
    assign lk.ok_pulse       = ok_q;
    assign lk.fail_pulse     = fail_q;
    assign lk.err_pulse      = err_q;

endmodule

// File: tb/tb_param_combo_lock.sv
// Directed bench for param_combo_lock: 4 digits, 3 attempts, 10-cycle base lockout, escalation cap 2.
module tb_param_combo_lock;
    import param_combo_lock_pkg::*;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int DM = 9;
    localparam int MA = 3;
    localparam int LC = 10;
    localparam int ME = 2;

    logic clk = 1'b0;
    logic rst;
    logic err_seen;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    param_combo_lock_if #(
        .NUM_DIGITS(ND), .DIGIT_W(DW), .MAX_ATTEMPTS(MA),
        .LOCKOUT_CYCLES(LC), .MAX_ESC(ME)
    ) lk ();

    param_combo_lock #(
        .NUM_DIGITS(ND), .DIGIT_W(DW), .DIGIT_MAX(DM), .MAX_ATTEMPTS(MA),
        .LOCKOUT_CYCLES(LC), .MAX_ESC(ME), .MASK_ENTRY(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lk  (lk)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Buttons go high for exactly one cycle; returns one cycle after release.
    task automatic press(input logic e, input logic bk, input logic ch, input logic rl,
                         input logic [3:0] d);
        lk.digit_in   = d;
        lk.btn_enter  = e;
        lk.btn_back   = bk;
        lk.btn_change = ch;
        lk.btn_relock = rl;
        @(negedge clk);
        err_seen      = lk.err_pulse;
        lk.btn_enter  = 1'b0;
        lk.btn_back   = 1'b0;
        lk.btn_change = 1'b0;
        lk.btn_relock = 1'b0;
        @(negedge clk);
    endtask

    task automatic enter_digit(input logic [3:0] d);
        press(1'b1, 1'b0, 1'b0, 1'b0, d);
    endtask

    // code is written first-digit-first, e.g. 16'h1234 enters 1,2,3,4.
    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) enter_digit(code[i*4 +: 4]);
    endtask

    task automatic fail3();
        for (int k = 0; k < 3; k++) enter_code(16'h9999);
    endtask

    task automatic wait_lockout(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (lk.mode == MODE_LOCKOUT && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, n, exp_cycles);
    endtask

    initial begin
        lk.digit_in   = '0;
        lk.btn_enter  = 1'b0;
        lk.btn_back   = 1'b0;
        lk.btn_change = 1'b0;
        lk.btn_relock = 1'b0;
        err_seen      = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check_eq("rst mode",     lk.mode, 2'b00);
        check_eq("rst mask",     lk.disp_mask, 4'h0);
        check_eq("rst digits",   lk.disp_digits, 16'h0000);
        check_eq("rst attempts", lk.attempts_left, 2'd3);
        check_eq("rst remain",   lk.lockout_remain, 0);
        check_eq("rst pulses",   {lk.ok_pulse, lk.fail_pulse, lk.err_pulse}, 3'b000);

        // Entry buffer editing in SET (real digits shown).
        enter_digit(4'd7);
        check_eq("set 7 mask",   lk.disp_mask, 4'b0001);
        check_eq("set 7 digits", lk.disp_digits, 16'h0007);
        press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check_eq("back mask",    lk.disp_mask, 4'b0000);
        press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check_eq("back@0 mask",  lk.disp_mask, 4'b0000);
        check_eq("back@0 digits", lk.disp_digits, 16'h0000);
        enter_digit(4'd5);
        check_eq("set 5 digits", lk.disp_digits, 16'h0005);
        press(1'b1, 1'b1, 1'b0, 1'b0, 4'd6);
        check_eq("enter+back mask",   lk.disp_mask, 4'b0011);
        check_eq("enter+back digits", lk.disp_digits, 16'h0065);
        enter_digit(4'd12);
        check_eq("bad digit err",  err_seen, 1'b1);
        check_eq("bad digit mask", lk.disp_mask, 4'b0011);

        lk.digit_in  = 4'd3;
        lk.btn_enter = 1'b1;
        repeat (100) @(negedge clk);
        lk.btn_enter = 1'b0;
        @(negedge clk);
        check_eq("held mask",   lk.disp_mask, 4'b0111);
        check_eq("held digits", lk.disp_digits, 16'h0365);
        repeat (3) press(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check_eq("cleared mask", lk.disp_mask, 4'b0000);

        // Commit 1234 as the password.
        enter_code(16'h1234);
        check_eq("set done mode", lk.mode, 2'b01);
        check_eq("set done mask", lk.disp_mask, 4'b0000);
        check_eq("set done att",  lk.attempts_left, 2'd3);

        enter_digit(4'd1);
        check_eq("locked mask",        lk.disp_mask, 4'b0001);
        check_eq("locked masked digit", lk.disp_digits, 16'h0000);
        enter_digit(4'd2);
        enter_digit(4'd3);
        enter_digit(4'd4);
        check_eq("open ok_pulse", lk.ok_pulse, 1'b1);
        check_eq("open mode",     lk.mode, 2'b11);
        @(negedge clk);
        check_eq("ok one cycle",  lk.ok_pulse, 1'b0);
        enter_digit(4'd5);
        check_eq("open ignores enter", lk.disp_mask, 4'b0000);
        press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check_eq("relock mode", lk.mode, 2'b01);

        // First lockout, step by step.
        enter_code(16'h9999);
        check_eq("wrong1 fail", lk.fail_pulse, 1'b1);
        check_eq("wrong1 att",  lk.attempts_left, 2'd2);
        enter_code(16'h9999);
        check_eq("wrong2 att",  lk.attempts_left, 2'd1);
        enter_code(16'h9999);
        check_eq("wrong3 fail",   lk.fail_pulse, 1'b1);
        check_eq("wrong3 att",    lk.attempts_left, 2'd0);
        check_eq("lockout1 mode", lk.mode, 2'b10);
        check_eq("lockout1 remain", lk.lockout_remain, 10);
        enter_digit(4'd1);
        check_eq("lockout ignores mask", lk.disp_mask, 4'b0000);
        check_eq("lockout remain 8",     lk.lockout_remain, 8);
        wait_lockout("lockout1 length", 8);
        check_eq("after lockout mode",   lk.mode, 2'b01);
        check_eq("after lockout att",    lk.attempts_left, 2'd3);
        check_eq("after lockout remain", lk.lockout_remain, 0);

        // Escalation 20, 40, then saturated 40.
        fail3();
        check_eq("lockout2 remain", lk.lockout_remain, 20);
        wait_lockout("lockout2 length", 20);
        fail3();
        check_eq("lockout3 remain", lk.lockout_remain, 40);
        wait_lockout("lockout3 length", 40);
        fail3();
        check_eq("lockout4 remain", lk.lockout_remain, 40);
        wait_lockout("lockout4 length", 40);

        enter_code(16'h1234);
        check_eq("ok after esc", lk.ok_pulse, 1'b1);
        press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        fail3();
        check_eq("level reset remain", lk.lockout_remain, 10);
        wait_lockout("lockout5 length", 10);

        // OPEN controls and password change.
        enter_code(16'h1234);
        check_eq("reopen mode", lk.mode, 2'b11);
        press(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        check_eq("change+relock mode", lk.mode, 2'b01);
        enter_code(16'h1234);
        press(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_eq("change mode", lk.mode, 2'b00);
        enter_code(16'h5678);
        check_eq("new pw mode", lk.mode, 2'b01);
        enter_code(16'h1234);
        check_eq("old pw fails", lk.fail_pulse, 1'b1);
        enter_code(16'h5678);
        check_eq("new pw ok", lk.ok_pulse, 1'b1);
        check_eq("new pw att", lk.attempts_left, 2'd3);

        // Reset in the middle of a lockout.
        press(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        fail3();
        check_eq("pre-rst mode", lk.mode, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst lockout mode",   lk.mode, 2'b00);
        check_eq("rst lockout remain", lk.lockout_remain, 0);
        check_eq("rst lockout att",    lk.attempts_left, 2'd3);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
